lsu_mem_bridge: RTL and testbench
=================================

Name: lsu_mem_bridge

Overview:
Load/store bridge between the core's data-access request stream and the data port of the dual-port memory model (mem2ports). It converts RV32 byte, halfword and word loads and stores into word-aligned memory reads and writes with byte strobes. It extracts and sign- or zero-extends load data, and flags misaligned, out-of-range and illegal accesses without touching memory. One access is in flight at a time, with a valid/ready handshake on both the request and response sides.

Parameters:
SIZE, 4096, memory size in bytes; any access with addr >= SIZE is an access fault.

Ports:
clk  in  1  clock; everything is on the rising edge.
resetb  in  1  reset; synchronous, active-high (resetb=1 resets on the clock edge).
req_valid  in  1  request valid.
req_ready  out  1  request accepted when req_valid && req_ready.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32 funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
rsp_valid  out  1  response valid; held until rsp_ready.
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  2  0 ok, 1 misaligned, 2 access fault, 3 illegal funct3.
rready  out  1  memory read enable.
raddr  out  30  memory read word address [31:2].
rresp  in  1  memory read response; arrives one cycle after rready.
rdata  in  32  memory read data, valid while rresp=1.
wready  out  1  memory write enable.
waddr  out  30  memory write word address [31:2].
wdata  out  32  lane-replicated write data.
wstrb  out  4  byte strobes.

Behaviour:
- States: IDLE, LOAD, RESP. req_ready = (state==IDLE). rsp_valid = (state==RESP).
- Reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, rready=0, wready=0, wstrb=0, raddr=0, waddr=0, wdata=0.
- Memory-side outputs are combinational from the request in the accept cycle only; they are 0 in every other cycle.
- Error check runs at accept, with priority illegal funct3 > misaligned > fault:
  - Illegal funct3: loads 3, 6, 7; stores >= 3.
  - Misaligned: half accesses with addr[0]!=0; word accesses with addr[1:0]!=0.
  - Fault: addr >= SIZE.
  - On error: no rready or wready; next state RESP with rsp_err set and rsp_rdata=0.
- Valid store accepted at cycle T:
  - Cycle T: wready=1, waddr=addr[31:2].
  - SB: wdata={4{wdata[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{wdata[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wdata=req_wdata, wstrb=1111.
  - Cycle T+1: RESP, rsp_err=0, rsp_rdata=0.
- Valid load accepted at cycle T:
  - Cycle T: rready=1, raddr=addr[31:2]. The bridge registers funct3 and addr[1:0]. Next state LOAD.
  - LOAD: when rresp=1, the bridge selects the lane from the saved offset, extends it (LB/LH sign, LBU/LHU zero, LW pass-through), registers rsp_rdata, and moves to RESP. rsp_valid is asserted at T+2.
  - If rresp=0 in LOAD, the bridge stays in LOAD. There is no timeout.
- RESP: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready. On rsp_ready the bridge returns to IDLE, and the next request can be accepted in the following cycle (no same-cycle turnaround).
- rresp while in IDLE or RESP is ignored.
- Reset mid-operation: resetb in any state forces IDLE and drops rsp_valid. A stale rresp on the next cycle is ignored.
- Read-after-write to the same word in consecutive requests is correct because the memory commits the write at the store's accept edge.

Test Plan:
- Reset: hold resetb=1 for 2 cycles -> rsp_valid=0, rready=0, wready=0, wstrb=0, req_ready=1 after release.
- SW 0x100 data 0xDEADBEEF -> wready=1, waddr=0x40, wstrb=1111, rsp_valid at T+1 with err 0. Then LW 0x100 -> rready at T, rsp_rdata=0xDEADBEEF at T+2.
- SB 0x103 data 0x80 -> wstrb=1000, wdata=0x80808080. Then LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080; LHU 0x102 -> 0x0000DEAD after the preceding SW.
- LH 0x101 -> rsp_err=1, no rready. SW 0x1000 with SIZE=4096 -> rsp_err=2, no wready. Load funct3=3 -> rsp_err=3.
- Backpressure: rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
- Reset in LOAD: assert resetb the cycle after a load accept -> IDLE, rsp_valid never asserted, the following rresp is ignored, and the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the core data-request stream to a word-wide memory port.
// Handles byte/half/word lanes, load extension and access error reporting.
module lsu_mem_bridge #(
    parameter int unsigned SIZE = 4096
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        rready,
    output logic [29:0] raddr,
    input  logic        rresp,
    input  logic [31:0] rdata,
    output logic        wready,
    output logic [29:0] waddr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;
    logic [1:0]  r_err;

    logic        w_acc;
    logic        w_illegal;
    logic        w_misal;
    logic        w_fault;
    logic [1:0]  w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign w_acc     = req_valid && req_ready;

    // funct3[1:0] encodes access width: 0 byte, 1 half, 2 word
    always_comb begin
        w_illegal = req_we ? (req_funct3 >= 3'd3)
                           : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
        w_misal   = ((req_funct3[1:0] == 2'd1) && req_addr[0])
                 || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
        w_fault   = (req_addr >= 32'(SIZE));
        if (w_illegal)
            w_err = 2'd3;
        else if (w_misal)
            w_err = 2'd1;
        else if (w_fault)
            w_err = 2'd2;
        else
            w_err = 2'd0;
    end

    always_comb begin
        unique case (r_off)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = r_off[1] ? rdata[31:16] : rdata[15:0];
        unique case (r_funct3)
            3'd0:    w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_ld_data = {{16{w_half[15]}}, w_half};
            3'd4:    w_ld_data = {24'd0, w_byte};
            3'd5:    w_ld_data = {16'd0, w_half};
            default: w_ld_data = rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetb)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        rready = 1'b0;
        raddr  = '0;
        wready = 1'b0;
        waddr  = '0;
        wdata  = '0;
        wstrb  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err != 2'd0) begin
                        w_next = S_RESP;
                    end else if (req_we) begin
                        w_next = S_RESP;
                        wready = 1'b1;
                        waddr  = req_addr[31:2];
                        unique case (req_funct3[1:0])
                            2'd0: begin
                                wdata = {4{req_wdata[7:0]}};
                                wstrb = 4'b0001 << req_addr[1:0];
                            end
                            2'd1: begin
                                wdata = {2{req_wdata[15:0]}};
                                wstrb = 4'b0011 << req_addr[1:0];
                            end
                            default: begin
                                wdata = req_wdata;
                                wstrb = 4'b1111;
                            end
                        endcase
                    end else begin
                        w_next = S_LOAD;
                        rready = 1'b1;
                        raddr  = req_addr[31:2];
                    end
                end
            end
            S_LOAD: begin
                if (rresp)
                    w_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Stores and errors respond with zero data; loads fill it from memory
    always_ff @(posedge clk) begin
        if (resetb) begin
            r_funct3 <= '0;
            r_off    <= '0;
            r_rdata  <= '0;
            r_err    <= '0;
        end else if (w_acc) begin
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_rdata  <= '0;
            r_err    <= w_err;
        end else if ((r_state == S_LOAD) && rresp) begin
            r_rdata  <= w_ld_data;
        end
    end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Scoreboard bench for lsu_mem_bridge with a small word memory model.
// Directed accesses; responses are checked by an independent monitor.
module tb_lsu_mem_bridge;

    logic        clk = 1'b0;
    logic        resetb;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        rready;
    logic [29:0] raddr;
    logic        rresp;
    logic [31:0] rdata;
    logic        wready;
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    lsu_mem_bridge #(.SIZE(4096)) dut (
        .clk(clk), .resetb(resetb),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rready(rready), .raddr(raddr),
        .rresp(rresp), .rdata(rdata),
        .wready(wready), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  err;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    bit   prev_v = 1'b0;
    bit   mem_delay = 1'b0;

    logic [31:0] mem [0:1023];
    logic        p1_v = 1'b0;
    logic        p2_v = 1'b0;
    logic [31:0] p1_d = '0;
    logic [31:0] p2_d = '0;

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = '0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wready) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b])
                    mem[waddr[9:0]][8*b +: 8] <= wdata[8*b +: 8];
        end
        p1_v <= rready;
        p1_d <= mem[raddr[9:0]];
        p2_v <= p1_v;
        p2_d <= p1_d;
    end

    assign rresp = mem_delay ? p2_v : p1_v;
    assign rdata = mem_delay ? p2_d : p1_d;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && !prev_v) begin
            if (q.size() == 0)
                chk("rsp_unexpected", 32'd1, 32'd0);
            else
                chk("rsp_latency", 32'(cyc - acc_cyc), 32'(q[0].lat));
        end
        if (rsp_valid && rsp_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rd);
            chk("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
            n_done++;
        end
        prev_v = rsp_valid;
    end

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic [1:0] exp_err,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                         input bit push, input bit wait_done);
        bit   ok;
        int   k;
        int   target;
        exp_t e;
        ok = (exp_err == 2'd0);
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready)
            chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        chk("rready", {31'd0, rready}, {31'd0, ok && !we});
        chk("raddr", {2'd0, raddr}, (ok && !we) ? {2'd0, a[31:2]} : 32'd0);
        chk("wready", {31'd0, wready}, {31'd0, ok && we});
        chk("waddr", {2'd0, waddr}, (ok && we) ? {2'd0, a[31:2]} : 32'd0);
        chk("wstrb", {28'd0, wstrb}, (ok && we) ? {28'd0, exp_strb} : 32'd0);
        chk("wdata", wdata, (ok && we) ? exp_wd : 32'd0);
        target = n_done + 1;
        if (push) begin
            e.rd  = exp_rd;
            e.err = exp_err;
            e.lat = (ok && !we) ? 2 : 1;
            q.push_back(e);
        end
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        if (wait_done) begin
            k = 0;
            while (n_done < target && k < 30) begin
                @(negedge clk);
                k++;
            end
            if (n_done < target)
                chk("rsp_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int k;
        resetb     = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetb = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);

        issue(1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 2'd0, 4'hF, 32'hDEADBEEF, 1, 1);
        issue(0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2'd0, 4'h0, 32'h0, 1, 1);
        issue(0, 3'd5, 32'h102, 32'h0, 32'h0000DEAD, 2'd0, 4'h0, 32'h0, 1, 1);
        issue(0, 3'd1, 32'h100, 32'h0, 32'hFFFFBEEF, 2'd0, 4'h0, 32'h0, 1, 1);
        issue(1, 3'd0, 32'h103, 32'h00000080, 32'h0, 2'd0, 4'h8, 32'h80808080, 1, 1);
        issue(0, 3'd0, 32'h103, 32'h0, 32'hFFFFFF80, 2'd0, 4'h0, 32'h0, 1, 1);
        issue(0, 3'd4, 32'h103, 32'h0, 32'h00000080, 2'd0, 4'h0, 32'h0, 1, 1);
        issue(1, 3'd1, 32'h102, 32'hABCD1234, 32'h0, 2'd0, 4'hC, 32'h12341234, 1, 1);
        issue(0, 3'd2, 32'h100, 32'h0, 32'h1234BEEF, 2'd0, 4'h0, 32'h0, 1, 1);
        issue(0, 3'd1, 32'h101, 32'h0, 32'h0, 2'd1, 4'h0, 32'h0, 1, 1);
        issue(1, 3'd2, 32'h1000, 32'h11111111, 32'h0, 2'd2, 4'h0, 32'h0, 1, 1);
        issue(0, 3'd3, 32'h100, 32'h0, 32'h0, 2'd3, 4'h0, 32'h0, 1, 1);
        issue(1, 3'd3, 32'h100, 32'h0, 32'h0, 2'd3, 4'h0, 32'h0, 1, 1);
        issue(0, 3'd7, 32'h1001, 32'h0, 32'h0, 2'd3, 4'h0, 32'h0, 1, 1);
        issue(0, 3'd2, 32'h1002, 32'h0, 32'h0, 2'd1, 4'h0, 32'h0, 1, 1);
        issue(1, 3'd2, 32'hFFC, 32'h0BADF00D, 32'h0, 2'd0, 4'hF, 32'h0BADF00D, 1, 1);
        issue(0, 3'd2, 32'hFFC, 32'h0, 32'h0BADF00D, 2'd0, 4'h0, 32'h0, 1, 1);

        // response backpressure
        rsp_ready = 1'b0;
        issue(0, 3'd2, 32'h100, 32'h0, 32'h1234BEEF, 2'd0, 4'h0, 32'h0, 1, 0);
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            #1;
            if (rsp_valid)
                break;
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h1234BEEF);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_drained", 32'(q.size()), 32'd0);

        // reset while waiting for read data; late rresp must be ignored
        mem_delay = 1'b1;
        issue(0, 3'd2, 32'h100, 32'h0, 32'h0, 2'd0, 4'h0, 32'h0, 0, 0);
        resetb = 1'b1;
        @(negedge clk);
        resetb = 1'b0;
        #1;
        chk("rl_stale_rresp", {31'd0, rresp}, 32'd1);
        chk("rl_req_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rl_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            #1;
        end
        mem_delay = 1'b0;
        issue(0, 3'd2, 32'hFFC, 32'h0, 32'h0BADF00D, 2'd0, 4'h0, 32'h0, 1, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
